// File: rtl/lsu_pkg.sv
// Shared LSU constants: access-size encodings, default address map, FSM states.
package lsu_pkg;

  localparam logic [1:0] LSU_SIZE_B = 2'b00;
  localparam logic [1:0] LSU_SIZE_H = 2'b01;
  localparam logic [1:0] LSU_SIZE_W = 2'b10;

  localparam logic [31:0] LSU_DMEM_BASE_DEF = 32'h0001_0000;
  localparam logic [31:0] LSU_MMIO_BASE_DEF = 32'h1000_0000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RAM_WAIT,
    ST_MMIO_WAIT,
    ST_RESP
  } lsu_state_t;

  // Illegal size or natural-alignment violation for the given byte offset.
  function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic bad;
    case (size)
      LSU_SIZE_B: bad = 1'b0;
      LSU_SIZE_H: bad = off[0];
      LSU_SIZE_W: bad = (off != 2'b00);
      default:    bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_if.sv
// LSU bus bundle: request/response handshake, data-RAM port and FIFO register port.
// Member names keep the original port names; slave is the LSU side.
interface lsu_if #(
  parameter int unsigned DMEM_AW = 10
) ();

  logic               req_valid_i;
  logic               req_ready_o;
  logic               req_we_i;
  logic [1:0]         req_size_i;
  logic               req_unsigned_i;
  logic [31:0]        req_addr_i;
  logic [31:0]        req_wdata_i;

  logic               resp_valid_o;
  logic [31:0]        resp_rdata_o;
  logic               resp_err_o;

  logic               dmem_en_o;
  logic [3:0]         dmem_we_o;
  logic [DMEM_AW-1:0] dmem_addr_o;
  logic [31:0]        dmem_wdata_o;
  logic [31:0]        dmem_rdata_i;

  logic               fifo_sel_o;
  logic               fifo_read_o;
  logic               fifo_write_o;
  logic [1:0]         fifo_addr_o;
  logic [7:0]         fifo_data_o;
  logic [7:0]         fifo_data_i;

  modport slave (
    input  req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
    input  dmem_rdata_i, fifo_data_i,
    output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
    output dmem_en_o, dmem_we_o, dmem_addr_o, dmem_wdata_o,
    output fifo_sel_o, fifo_read_o, fifo_write_o, fifo_addr_o, fifo_data_o
  );

  modport master (
    output req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
    output dmem_rdata_i, fifo_data_i,
    input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
    input  dmem_en_o, dmem_we_o, dmem_addr_o, dmem_wdata_o,
    input  fifo_sel_o, fifo_read_o, fifo_write_o, fifo_addr_o, fifo_data_o
  );

endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: store byte-enables and data replication,
// load lane extraction with sign/zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  st_size_i,
  input  logic [1:0]  st_off_i,
  input  logic [31:0] st_data_i,
  output logic [3:0]  st_mask_o,
  output logic [31:0] st_data_o,

  input  logic [1:0]  ld_size_i,
  input  logic [1:0]  ld_off_i,
  input  logic        ld_unsigned_i,
  input  logic [31:0] ld_word_i,
  output logic [31:0] ld_data_o
);

  logic [31:0] ld_shift;

  // Store side: lane mask from size/offset, data copied into every lane.
  always_comb begin
    st_mask_o = '0;
    st_data_o = st_data_i;
    case (st_size_i)
      LSU_SIZE_B: begin
        st_mask_o = 4'b0001 << st_off_i;
        st_data_o = {4{st_data_i[7:0]}};
      end
      LSU_SIZE_H: begin
        st_mask_o = 4'b0011 << {st_off_i[1], 1'b0};
        st_data_o = {2{st_data_i[15:0]}};
      end
      LSU_SIZE_W: st_mask_o = '1;
      default:    st_mask_o = '0;
    endcase
  end

  // Load side: shift addressed lane down to bit 0, then extend.
  always_comb begin
    ld_shift  = ld_word_i >> {ld_off_i, 3'b000};
    ld_data_o = ld_word_i;
    case (ld_size_i)
      LSU_SIZE_B: ld_data_o = ld_unsigned_i ? {24'h0, ld_shift[7:0]}
                                            : {{24{ld_shift[7]}}, ld_shift[7:0]};
      LSU_SIZE_H: ld_data_o = ld_unsigned_i ? {16'h0, ld_shift[15:0]}
                                            : {{16{ld_shift[15]}}, ld_shift[15:0]};
      default:    ld_data_o = ld_word_i;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: decodes a request into a data-RAM or FIFO-register access,
// issues single-cycle strobes in the accept cycle and returns a one-cycle response.
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned DMEM_AW   = 10,
  parameter logic [31:0] DMEM_BASE = LSU_DMEM_BASE_DEF,
  parameter logic [31:0] MMIO_BASE = LSU_MMIO_BASE_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  lsu_if.slave bus
);

  // 33-bit bounds so a window touching the top of the address space cannot wrap.
  localparam logic [32:0] DMEM_LO = {1'b0, DMEM_BASE};
  localparam logic [32:0] DMEM_HI = {1'b0, DMEM_BASE} + (33'd4 << DMEM_AW);
  localparam logic [32:0] MMIO_LO = {1'b0, MMIO_BASE};
  localparam logic [32:0] MMIO_HI = {1'b0, MMIO_BASE} + 33'd4;

  lsu_state_t  state_q, state_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_err_q, resp_err_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  ld_size_q, ld_size_d;
  logic [1:0]  ld_off_q, ld_off_d;
  logic        ld_uns_q, ld_uns_d;

  logic [32:0] addr_x;
  logic        ram_hit, mmio_hit, fault, accept, go;
  logic [3:0]  st_mask;
  logic [31:0] st_data, ld_word, ld_data;

  // Address decode and fault classification of the presented request.
  always_comb begin
    addr_x   = {1'b0, bus.req_addr_i};
    ram_hit  = (addr_x >= DMEM_LO) && (addr_x < DMEM_HI);
    mmio_hit = (addr_x >= MMIO_LO) && (addr_x < MMIO_HI);
    fault    = lsu_misaligned(bus.req_size_i, bus.req_addr_i[1:0])
             | !(ram_hit || mmio_hit)
             | (mmio_hit && (bus.req_size_i != LSU_SIZE_B));
    bus.req_ready_o = (state_q == ST_IDLE) && !rst_i;
    accept = bus.req_valid_i && bus.req_ready_o;
    go     = accept && !fault;
  end

  // MMIO loads reuse the byte extractor with the FIFO byte placed in lane 0.
  always_comb begin
    ld_word = (state_q == ST_MMIO_WAIT) ? {24'h0, bus.fifo_data_i} : bus.dmem_rdata_i;
  end

  lsu_align u_align (
    .st_size_i     (bus.req_size_i),
    .st_off_i      (bus.req_addr_i[1:0]),
    .st_data_i     (bus.req_wdata_i),
    .st_mask_o     (st_mask),
    .st_data_o     (st_data),
    .ld_size_i     (ld_size_q),
    .ld_off_i      (ld_off_q),
    .ld_unsigned_i (ld_uns_q),
    .ld_word_i     (ld_word),
    .ld_data_o     (ld_data)
  );

  // Strobes exist only in the accept cycle of a non-faulting request.
  always_comb begin
    bus.dmem_en_o    = go && ram_hit;
    bus.dmem_we_o    = (go && ram_hit && bus.req_we_i) ? st_mask : 4'b0000;
    bus.dmem_addr_o  = bus.req_addr_i[DMEM_AW+1:2] - DMEM_BASE[DMEM_AW+1:2];
    bus.dmem_wdata_o = st_data;
    bus.fifo_sel_o   = go && mmio_hit;
    bus.fifo_read_o  = go && mmio_hit && !bus.req_we_i;
    bus.fifo_write_o = go && mmio_hit && bus.req_we_i;
    bus.fifo_addr_o  = bus.req_addr_i[1:0];
    bus.fifo_data_o  = bus.req_wdata_i[7:0];
  end

  // Next-state and response computation.
  always_comb begin
    state_d      = state_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    rdata_d      = rdata_q;
    ld_size_d    = ld_size_q;
    ld_off_d     = ld_off_q;
    ld_uns_d     = ld_uns_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          ld_size_d = bus.req_size_i;
          ld_off_d  = ram_hit ? bus.req_addr_i[1:0] : 2'b00;
          ld_uns_d  = bus.req_unsigned_i;
          if (fault) begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            rdata_d      = '0;
          end else if (bus.req_we_i) begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            rdata_d      = '0;
          end else if (ram_hit) begin
            state_d = ST_RAM_WAIT;
          end else begin
            state_d = ST_MMIO_WAIT;
          end
        end
      end
      ST_RAM_WAIT, ST_MMIO_WAIT: begin
        state_d      = ST_RESP;
        resp_valid_d = 1'b1;
        rdata_d      = ld_data;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered response outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      rdata_q      <= '0;
      ld_size_q    <= '0;
      ld_off_q     <= '0;
      ld_uns_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      rdata_q      <= rdata_d;
      ld_size_q    <= ld_size_d;
      ld_off_q     <= ld_off_d;
      ld_uns_q     <= ld_uns_d;
    end
  end

  assign bus.resp_valid_o = resp_valid_q;
  assign bus.resp_err_o   = resp_err_q;
  assign bus.resp_rdata_o = rdata_q;

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: directed vectors push expected responses,
// an independent negedge monitor pops and compares them.
module tb_lsu;

  localparam int unsigned AW   = 10;
  localparam logic [31:0] DB   = 32'h0001_0000;
  localparam logic [31:0] MB   = 32'h1000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lsu_if #(.DMEM_AW(AW)) bus ();

  lsu #(.DMEM_AW(AW), .DMEM_BASE(DB), .MMIO_BASE(MB)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // Data RAM: byte-lane writes, registered read one cycle after strobe.
  logic [31:0] mem [1024];
  initial for (int i = 0; i < 1024; i++) mem[i] = '0;
  always @(posedge clk) begin
    if (bus.dmem_en_o) begin
      for (int l = 0; l < 4; l++)
        if (bus.dmem_we_o[l]) mem[bus.dmem_addr_o][8*l +: 8] <= bus.dmem_wdata_o[8*l +: 8];
      bus.dmem_rdata_i <= mem[bus.dmem_addr_o];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          due;
  } exp_t;
  exp_t sb[$];

  // Response monitor.
  always @(negedge clk) begin
    if (bus.resp_valid_o === 1'b1) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_resp: got resp_valid=1 expected none (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("resp_rdata", bus.resp_rdata_o, e.rd);
        chk("resp_err", 32'(bus.resp_err_o), 32'(e.err));
        chk("resp_cycle", cyc, e.due);
      end
    end
  end

  // Strobe monitor: no strobe outside an accept cycle or during reset.
  always @(negedge clk) begin
    if (rst || !bus.req_valid_i || !bus.req_ready_o)
      chk("idle_strobes", {27'h0, bus.dmem_en_o, bus.dmem_we_o != 4'h0,
                           bus.fifo_sel_o, bus.fifo_read_o, bus.fifo_write_o}, 32'h0);
  end

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [7:0]  fdin;
    logic        en;
    logic [3:0]  dwe;
    logic [9:0]  da;
    logic [31:0] dwd;
    logic        fsel;
    logic        frd;
    logic        fwr;
    logic [1:0]  fa;
    logic [7:0]  fd;
    logic [31:0] rd;
    logic        err;
    int          lat;
  } vec_t;

  function automatic vec_t V(
    input logic we, input logic [1:0] size, input logic uns, input logic [31:0] addr,
    input logic [31:0] wdata, input logic [7:0] fdin, input logic en, input logic [3:0] dwe,
    input logic [9:0] da, input logic [31:0] dwd, input logic fsel, input logic frd,
    input logic fwr, input logic [1:0] fa, input logic [7:0] fd, input logic [31:0] rd,
    input logic err, input int lat);
    vec_t v;
    v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata; v.fdin = fdin;
    v.en = en; v.dwe = dwe; v.da = da; v.dwd = dwd; v.fsel = fsel; v.frd = frd;
    v.fwr = fwr; v.fa = fa; v.fd = fd; v.rd = rd; v.err = err; v.lat = lat;
    return v;
  endfunction

  task automatic run_vec(input int idx, input vec_t v);
    int waited = 0;
    exp_t e;
    @(posedge clk); #1;
    bus.req_we_i       = v.we;
    bus.req_size_i     = v.size;
    bus.req_unsigned_i = v.uns;
    bus.req_addr_i     = v.addr;
    bus.req_wdata_i    = v.wdata;
    bus.fifo_data_i    = v.fdin;
    bus.req_valid_i    = 1'b1;
    @(negedge clk);
    while (bus.req_ready_o !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (bus.req_ready_o !== 1'b1) begin
      tests++;
      fails++;
      $display("FAIL v%0d ready_timeout: got ready=%b expected 1", idx, bus.req_ready_o);
      bus.req_valid_i = 1'b0;
      return;
    end
    chk($sformatf("v%0d dmem_en", idx), 32'(bus.dmem_en_o), 32'(v.en));
    chk($sformatf("v%0d dmem_we", idx), 32'(bus.dmem_we_o), 32'(v.dwe));
    if (v.en) chk($sformatf("v%0d dmem_addr", idx), 32'(bus.dmem_addr_o), 32'(v.da));
    if (v.dwe != 4'h0) chk($sformatf("v%0d dmem_wdata", idx), bus.dmem_wdata_o, v.dwd);
    chk($sformatf("v%0d fifo_strobes", idx),
        32'({bus.fifo_sel_o, bus.fifo_read_o, bus.fifo_write_o}), 32'({v.fsel, v.frd, v.fwr}));
    if (v.fsel) begin
      chk($sformatf("v%0d fifo_addr", idx), 32'(bus.fifo_addr_o), 32'(v.fa));
      if (v.fwr) chk($sformatf("v%0d fifo_data", idx), 32'(bus.fifo_data_o), 32'(v.fd));
    end
    e.rd = v.rd; e.err = v.err; e.due = cyc + v.lat;
    sb.push_back(e);
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d ready_after_accept", idx), 32'(bus.req_ready_o), 32'h0);
  endtask

  vec_t vecs[$];

  initial begin
    int w;
    bus.req_valid_i = 1'b0; bus.req_we_i = 1'b0; bus.req_size_i = 2'b00;
    bus.req_unsigned_i = 1'b0; bus.req_addr_i = '0; bus.req_wdata_i = '0;
    bus.fifo_data_i = '0; bus.dmem_rdata_i = '0;

    //           we sz    u  addr          wdata         fdin  en we     da     dwd           fs fr fw fa    fd     rd            er lat
    vecs.push_back(V(1, 2'b10, 0, DB+32'h0,    32'h0000_80F0, 8'h00, 1, 4'b1111, 10'h0, 32'h0000_80F0, 0, 0, 0, 2'd0, 8'h00, 32'h0,          0, 1));
    vecs.push_back(V(1, 2'b00, 0, DB+32'h3,    32'h0000_00A5, 8'h00, 1, 4'b1000, 10'h0, 32'hA5A5_A5A5, 0, 0, 0, 2'd0, 8'h00, 32'h0,          0, 1));
    vecs.push_back(V(0, 2'b01, 0, DB+32'h0,    32'h0,         8'h00, 1, 4'b0000, 10'h0, 32'h0,         0, 0, 0, 2'd0, 8'h00, 32'hFFFF_80F0, 0, 2));
    vecs.push_back(V(0, 2'b01, 1, DB+32'h0,    32'h0,         8'h00, 1, 4'b0000, 10'h0, 32'h0,         0, 0, 0, 2'd0, 8'h00, 32'h0000_80F0, 0, 2));
    vecs.push_back(V(0, 2'b00, 0, DB+32'h3,    32'h0,         8'h00, 1, 4'b0000, 10'h0, 32'h0,         0, 0, 0, 2'd0, 8'h00, 32'hFFFF_FFA5, 0, 2));
    vecs.push_back(V(0, 2'b00, 1, DB+32'h1,    32'h0,         8'h00, 1, 4'b0000, 10'h0, 32'h0,         0, 0, 0, 2'd0, 8'h00, 32'h0000_0080, 0, 2));
    vecs.push_back(V(0, 2'b10, 0, DB+32'h0,    32'h0,         8'h00, 1, 4'b0000, 10'h0, 32'h0,         0, 0, 0, 2'd0, 8'h00, 32'hA500_80F0, 0, 2));
    vecs.push_back(V(1, 2'b01, 0, DB+32'h6,    32'h0000_1234, 8'h00, 1, 4'b1100, 10'h1, 32'h1234_1234, 0, 0, 0, 2'd0, 8'h00, 32'h0,          0, 1));
    vecs.push_back(V(0, 2'b01, 0, DB+32'h6,    32'h0,         8'h00, 1, 4'b0000, 10'h1, 32'h0,         0, 0, 0, 2'd0, 8'h00, 32'h0000_1234, 0, 2));
    vecs.push_back(V(0, 2'b10, 0, DB+32'hFFC,  32'h0,         8'h00, 1, 4'b0000, 10'h3FF, 32'h0,       0, 0, 0, 2'd0, 8'h00, 32'h0,          0, 2));
    vecs.push_back(V(0, 2'b10, 0, DB+32'h2,    32'h0,         8'h00, 0, 4'b0000, 10'h0, 32'h0,         0, 0, 0, 2'd0, 8'h00, 32'h0,          1, 1));
    vecs.push_back(V(0, 2'b11, 0, DB+32'h0,    32'h0,         8'h00, 0, 4'b0000, 10'h0, 32'h0,         0, 0, 0, 2'd0, 8'h00, 32'h0,          1, 1));
    vecs.push_back(V(0, 2'b10, 0, 32'h2000_0000, 32'h0,       8'h00, 0, 4'b0000, 10'h0, 32'h0,         0, 0, 0, 2'd0, 8'h00, 32'h0,          1, 1));
    vecs.push_back(V(1, 2'b01, 0, DB+32'h1,    32'hFFFF_FFFF, 8'h00, 0, 4'b0000, 10'h0, 32'h0,         0, 0, 0, 2'd0, 8'h00, 32'h0,          1, 1));
    vecs.push_back(V(0, 2'b10, 0, DB+32'h1000, 32'h0,         8'h00, 0, 4'b0000, 10'h0, 32'h0,         0, 0, 0, 2'd0, 8'h00, 32'h0,          1, 1));
    vecs.push_back(V(0, 2'b10, 0, DB-32'h4,    32'h0,         8'h00, 0, 4'b0000, 10'h0, 32'h0,         0, 0, 0, 2'd0, 8'h00, 32'h0,          1, 1));
    vecs.push_back(V(0, 2'b01, 0, MB+32'h0,    32'h0,         8'h00, 0, 4'b0000, 10'h0, 32'h0,         0, 0, 0, 2'd0, 8'h00, 32'h0,          1, 1));
    vecs.push_back(V(0, 2'b00, 1, MB+32'h1,    32'h0,         8'h41, 0, 4'b0000, 10'h0, 32'h0,         1, 1, 0, 2'd1, 8'h00, 32'h0000_0041, 0, 2));
    vecs.push_back(V(0, 2'b00, 0, MB+32'h3,    32'h0,         8'h90, 0, 4'b0000, 10'h0, 32'h0,         1, 1, 0, 2'd3, 8'h00, 32'hFFFF_FF90, 0, 2));
    vecs.push_back(V(0, 2'b00, 1, MB+32'h2,    32'h0,         8'h90, 0, 4'b0000, 10'h0, 32'h0,         1, 1, 0, 2'd2, 8'h00, 32'h0000_0090, 0, 2));
    vecs.push_back(V(1, 2'b00, 0, MB+32'h0,    32'h1234_567E, 8'h00, 0, 4'b0000, 10'h0, 32'h0,         1, 0, 1, 2'd0, 8'h7E, 32'h0,          0, 1));
    vecs.push_back(V(0, 2'b10, 0, DB+32'h4,    32'h0,         8'h00, 1, 4'b0000, 10'h1, 32'h0,         0, 0, 0, 2'd0, 8'h00, 32'h1234_0000, 0, 2));

    // Reset state.
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_ready", 32'(bus.req_ready_o), 32'h0);
    chk("rst_resp", {bus.resp_rdata_o[30:0], bus.resp_valid_o}, 32'h0);
    chk("rst_err", 32'(bus.resp_err_o), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 32'(bus.req_ready_o), 32'h1);

    foreach (vecs[i]) run_vec(i, vecs[i]);

    w = 0;
    while (sb.size() != 0 && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("sb_drained", sb.size(), 0);

    // Load data holds between responses.
    repeat (3) @(negedge clk);
    chk("rdata_hold", bus.resp_rdata_o, 32'h1234_0000);

    // Reset while the FSM waits for RAM read data: load is dropped.
    @(posedge clk); #1;
    bus.req_we_i = 1'b0; bus.req_size_i = 2'b10; bus.req_unsigned_i = 1'b0;
    bus.req_addr_i = DB + 32'h4; bus.req_valid_i = 1'b1;
    @(negedge clk);
    chk("abort_accept", 32'({bus.req_ready_o, bus.dmem_en_o}), 32'h3);
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_ready_in_rst", 32'(bus.req_ready_o), 32'h0);
    chk("abort_rdata_cleared", bus.resp_rdata_o, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_ready_after_rst", 32'(bus.req_ready_o), 32'h1);
    repeat (4) @(negedge clk);
    chk("abort_no_pending", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish by 200000");
    $fatal(1, "timeout");
  end

endmodule
